switch_conditioner: RTL

Input-side conditioner for the board's slide switches and push buttons. Synchronises each raw pad signal into `clk`, debounces it with a per-channel stability counter, and publishes a clean level vector plus single-cycle rise/fall strobes. It sits between the `SW` pins and every consumer of switch state, such as the LED controller, clock divider and 7-segment logic. Those consumers then see glitch-free levels and can act on edges instead of raw asynchronous inputs.

---
 rtl/switch_conditioner_if.sv | 41 ++++
 rtl/switch_conditioner.sv | 106 ++++++++++
 2 files changed

// File: rtl/switch_conditioner_if.sv
// Bundle of switch-side signals between the pads and the conditioner.
// The sticky change-latch pair exists only when SWCOND_STICKY_EN is defined.
interface switch_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             any_change;
`ifdef SWCOND_STICKY_EN
  logic [WIDTH-1:0] chg_latch;
  logic             chg_clr;
`endif

  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  any_change
`ifdef SWCOND_STICKY_EN
    ,
    output chg_clr,
    input  chg_latch
`endif
  );

  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output any_change
`ifdef SWCOND_STICKY_EN
    ,
    input  chg_clr,
    output chg_latch
`endif
  );
endinterface

// File: rtl/switch_conditioner.sv
// Two-flop synchroniser plus per-channel stability-counter debouncer with rise/fall strobes.
// Optional sticky change latch enabled by defining SWCOND_STICKY_EN.
module switch_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input logic                clk,
  input logic                rst_n,
  switch_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] fall_next;
  logic             any_reg;
  logic             any_next;

  // Each channel owns its counter; only the proposed next stable bit leaves the block.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             stable_bit_next;

    always_comb begin
      cnt_next        = cnt_reg;
      stable_bit_next = stable_reg[gi];
      if (sync2_reg[gi] == stable_reg[gi]) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
        stable_bit_next = sync2_reg[gi];
        cnt_next        = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end

    assign stable_next[gi] = stable_bit_next;
  end

  // Strobes come from next-vs-current so they line up with the level change.
  always_comb begin
    rise_next = stable_next & ~stable_reg;
    fall_next = ~stable_next & stable_reg;
    any_next  = |(rise_next | fall_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      stable_reg <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      any_reg    <= 1'b0;
    end else begin
      sync1_reg  <= bus.sw_raw;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      any_reg    <= any_next;
    end
  end

  assign bus.sw_stable  = stable_reg;
  assign bus.sw_rise    = rise_reg;
  assign bus.sw_fall    = fall_reg;
  assign bus.any_change = any_reg;

`ifdef SWCOND_STICKY_EN
  logic [WIDTH-1:0] latch_reg;
  logic [WIDTH-1:0] latch_next;

  // Set is OR-ed after the clear so a coincident strobe keeps the bit high.
  always_comb begin
    latch_next = (bus.chg_clr ? '0 : latch_reg) | rise_reg | fall_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_reg <= '0;
    end else begin
      latch_reg <= latch_next;
    end
  end

  assign bus.chg_latch = latch_reg;
`endif

endmodule
